// File: rtl/rr_req_scheduler.sv
// Round-robin scheduler: one grant at a time among 16 requesters, descending search from a rotating pointer.
// Latency: request sampled in IDLE -> registered grant one edge later; release/drop/timeout -> idle one edge later.
// Backpressure: a grant is held until release_i, loss of the owner's request, or MAX_HOLD cycles elapse.
module rr_req_scheduler #(
    parameter int         N_REQ     = 16,
    parameter logic [7:0] MAX_HOLD  = 8'd255,
    parameter logic [7:0] IDLE_CODE = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [7:0]       grant_idx,
    output logic             timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] ptr;
    logic [3:0] owner;
    logic [7:0] hold_cnt;

    logic       win_found;
    logic [3:0] win_idx;
    logic [3:0] cand;
    logic       end_grant;
    logic       hold_expired;

    // Priority search: walk ptr, ptr-1, ... with 4-bit wrap; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        cand      = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr - 4'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant-end conditions, in priority order release > drop > hold expiry.
    always_comb begin
        hold_expired = (hold_cnt == (MAX_HOLD - 8'd1));
        end_grant    = release_i || !req[owner] || hold_expired;
    end

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= 4'hF;
            owner       <= 4'd0;
            hold_cnt    <= 8'd0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= IDLE_CODE;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state       <= S_GRANT;
                        owner       <= win_idx;
                        hold_cnt    <= 8'd0;
                        grant       <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        grant_valid <= 1'b1;
                        grant_idx   <= {4'b0000, win_idx};
                    end
                end
                S_GRANT: begin
                    if (end_grant) begin
                        // Resume the search just below the finished owner; no re-search this cycle.
                        state       <= S_IDLE;
                        ptr         <= owner - 4'd1;
                        hold_cnt    <= 8'd0;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= IDLE_CODE;
                        timeout     <= !release_i && req[owner];
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_req_scheduler.sv
// Directed bench for rr_req_scheduler: three instances (MAX_HOLD 255, 4, 2) share stimulus.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Expected values are hand-derived constants.
module tb_rr_req_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        release_i;

    logic [15:0] grant_a, grant_4, grant_2;
    logic        vld_a, vld_4, vld_2;
    logic [7:0]  idx_a, idx_4, idx_2;
    logic        to_a, to_4, to_2;

    int n_tests;
    int n_fail;

    rr_req_scheduler #(.N_REQ(16), .MAX_HOLD(8'd255), .IDLE_CODE(8'hF0)) dut (
        .clk(clk), .rst(rst), .req(req), .release_i(release_i),
        .grant(grant_a), .grant_valid(vld_a), .grant_idx(idx_a), .timeout(to_a)
    );

    rr_req_scheduler #(.N_REQ(16), .MAX_HOLD(8'd4), .IDLE_CODE(8'hF0)) dut_m4 (
        .clk(clk), .rst(rst), .req(req), .release_i(release_i),
        .grant(grant_4), .grant_valid(vld_4), .grant_idx(idx_4), .timeout(to_4)
    );

    rr_req_scheduler #(.N_REQ(16), .MAX_HOLD(8'd2), .IDLE_CODE(8'hF0)) dut_m2 (
        .clk(clk), .rst(rst), .req(req), .release_i(release_i),
        .grant(grant_2), .grant_valid(vld_2), .grant_idx(idx_2), .timeout(to_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        release_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = 16'h0000;
        release_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_grant", 32'(grant_a), 32'h0);
        chk("rst_valid", 32'(vld_a), 32'h0);
        chk("rst_idx", 32'(idx_a), 32'hF0);
        chk("rst_timeout", 32'(to_a), 32'h0);

        // No requests: stays idle
        tick();
        chk("idle_noreq_idx", 32'(idx_a), 32'hF0);

        // First arbitration picks the highest index, then rotation reaches 0
        req = 16'h8001;
        tick();
        chk("s1_grant15", 32'(grant_a), 32'h8000);
        chk("s1_idx15", 32'(idx_a), 32'h0F);
        chk("s1_valid15", 32'(vld_a), 32'h1);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk("s1_gap_valid", 32'(vld_a), 32'h0);
        chk("s1_gap_idx", 32'(idx_a), 32'hF0);
        chk("s1_gap_timeout", 32'(to_a), 32'h0);
        tick();
        chk("s1_grant0", 32'(grant_a), 32'h0001);
        chk("s1_idx0", 32'(idx_a), 32'h00);

        // Full rotation with all requesters active
        do_reset();
        req = 16'hFFFF;
        for (int j = 0; j < 17; j++) begin
            tick();
            chk("rot_idx", 32'(idx_a), 32'((15 - j) & 15));
            chk("rot_valid", 32'(vld_a), 32'h1);
            release_i = 1'b1;
            tick();
            release_i = 1'b0;
            chk("rot_gap_valid", 32'(vld_a), 32'h0);
        end

        // Hold timeout with MAX_HOLD = 4
        do_reset();
        req = 16'h0010;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("m4_hold_idx", 32'(idx_4), 32'h04);
            chk("m4_hold_timeout", 32'(to_4), 32'h0);
        end
        tick();
        chk("m4_timeout_pulse", 32'(to_4), 32'h1);
        chk("m4_timeout_valid", 32'(vld_4), 32'h0);
        chk("m4_timeout_idx", 32'(idx_4), 32'hF0);
        chk("m255_still_granted", 32'(idx_a), 32'h04);
        chk("m255_no_timeout", 32'(to_a), 32'h0);
        tick();
        chk("m4_regrant_idx", 32'(idx_4), 32'h04);
        chk("m4_pulse_one_cycle", 32'(to_4), 32'h0);

        // Request drop ends the grant without timeout; pointer moves below owner
        do_reset();
        req = 16'h0088;
        tick();
        chk("drop_grant7", 32'(idx_a), 32'h07);
        tick();
        chk("drop_hold7", 32'(idx_a), 32'h07);
        req = 16'h0108;
        tick();
        chk("drop_valid", 32'(vld_a), 32'h0);
        chk("drop_no_timeout", 32'(to_a), 32'h0);
        tick();
        chk("drop_next3", 32'(idx_a), 32'h03);
        chk("drop_next3_onehot", 32'(grant_a), 32'h0008);

        // Release on the final hold cycle beats the timeout (MAX_HOLD = 2)
        do_reset();
        req = 16'h0010;
        tick();
        chk("m2_grant", 32'(idx_2), 32'h04);
        tick();
        chk("m2_hold1", 32'(idx_2), 32'h04);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk("m2_release_no_timeout", 32'(to_2), 32'h0);
        chk("m2_release_valid", 32'(vld_2), 32'h0);
        tick();
        chk("m2_regrant", 32'(idx_2), 32'h04);
        tick();
        tick();
        chk("m2_timeout_pulse", 32'(to_2), 32'h1);

        // Reset mid-grant restores idle outputs and the pointer
        do_reset();
        req = 16'h0200;
        tick();
        chk("rstg_first9", 32'(idx_a), 32'h09);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        tick();
        chk("rstg_second9", 32'(idx_a), 32'h09);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstg_grant", 32'(grant_a), 32'h0);
        chk("rstg_idx", 32'(idx_a), 32'hF0);
        chk("rstg_timeout", 32'(to_a), 32'h0);
        chk("rstg_valid", 32'(vld_a), 32'h0);
        req = 16'h0201;
        tick();
        chk("rstg_ptr_reset", 32'(idx_a), 32'h09);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
